// File: rtl/mfp_eic_scheduler.sv
// EIC interrupt scheduler: per-channel priority table, one-channel-per-cycle scan,
// presents the winner to the CPU, and pulses a clear command after acknowledge.
module mfp_eic_scheduler #(
  parameter int CHANNELS   = 8,
  parameter int PRIO_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic [CHANNELS-1:0]   pending,
  input  logic                  cfg_write_enable,
  input  logic [5:0]            cfg_write_channel,
  input  logic [PRIO_WIDTH-1:0] cfg_write_priority,
  input  logic [5:0]            cfg_read_channel,
  output logic [PRIO_WIDTH-1:0] cfg_read_priority,
  input  logic [7:0]            EIC_IPL,
  input  logic                  EIC_IAck,
  output logic [7:0]            EIC_Interrupt,
  output logic [5:0]            EIC_Vector,
  output logic                  clear_valid,
  output logic [5:0]            clear_channel,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT, S_CLEAR} state_t;

  localparam logic [5:0] LAST = 6'(CHANNELS - 1);

  state_t                state_q, state_d;
  logic [PRIO_WIDTH-1:0] prio_q [CHANNELS];
  logic [5:0]            idx_q, idx_d;
  logic [5:0]            best_ch_q, best_ch_d;
  logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
  logic [7:0]            int_q, int_d;
  logic [5:0]            vec_q, vec_d;
  logic                  clr_q, clr_d;
  logic [5:0]            clr_ch_q, clr_ch_d;
  logic                  busy_q, busy_d;

  logic                  pend_idx, pend_best;
  logic [PRIO_WIDTH-1:0] prio_idx, prio_best, rd_prio;
  logic                  take;
  logic [PRIO_WIDTH-1:0] scan_prio;
  logic [5:0]            scan_ch;

  // Table/flag lookups by decode so out-of-range indices read as zero.
  always_comb begin
    pend_idx  = 1'b0;
    pend_best = 1'b0;
    prio_idx  = '0;
    prio_best = '0;
    rd_prio   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (idx_q == 6'(i)) begin
        pend_idx = pending[i];
        prio_idx = prio_q[i];
      end
      if (best_ch_q == 6'(i)) begin
        pend_best = pending[i];
        prio_best = prio_q[i];
      end
      if (cfg_read_channel == 6'(i)) rd_prio = prio_q[i];
    end
  end

  assign cfg_read_priority = rd_prio;

  // Strict compare keeps the lowest index on a tie.
  always_comb begin
    take      = pend_idx && (prio_idx > best_prio_q);
    scan_prio = take ? prio_idx : best_prio_q;
    scan_ch   = take ? idx_q : best_ch_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_ch_d   = best_ch_q;
    best_prio_d = best_prio_q;
    int_d       = int_q;
    vec_d       = vec_q;
    clr_d       = 1'b0;
    clr_ch_d    = clr_ch_q;
    case (state_q)
      S_IDLE: begin
        if (|pending) begin
          state_d     = S_SCAN;
          idx_d       = '0;
          best_ch_d   = '0;
          best_prio_d = '0;
        end
      end
      S_SCAN: begin
        best_prio_d = scan_prio;
        best_ch_d   = scan_ch;
        idx_d       = idx_q + 6'd1;
        if (idx_q == LAST) begin
          if (8'(scan_prio) > EIC_IPL) begin
            state_d = S_PRESENT;
            int_d   = 8'(scan_prio);
            vec_d   = scan_ch;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_PRESENT: begin
        if (EIC_IAck) begin
          state_d  = S_CLEAR;
          int_d    = '0;
          clr_d    = 1'b1;
          clr_ch_d = best_ch_q;
        end else if (!pend_best || prio_best == '0 || EIC_IPL >= 8'(best_prio_q)) begin
          state_d = S_IDLE;
          int_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      best_ch_q   <= '0;
      best_prio_q <= '0;
      int_q       <= '0;
      vec_q       <= '0;
      clr_q       <= 1'b0;
      clr_ch_q    <= '0;
      busy_q      <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) prio_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      best_ch_q   <= best_ch_d;
      best_prio_q <= best_prio_d;
      int_q       <= int_d;
      vec_q       <= vec_d;
      clr_q       <= clr_d;
      clr_ch_q    <= clr_ch_d;
      busy_q      <= busy_d;
      for (int i = 0; i < CHANNELS; i++)
        if (cfg_write_enable && cfg_write_channel == 6'(i)) prio_q[i] <= cfg_write_priority;
    end
  end

  assign EIC_Interrupt = int_q;
  assign EIC_Vector    = vec_q;
  assign clear_valid   = clr_q;
  assign clear_channel = clr_ch_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mfp_eic_scheduler.sv
// Bench for mfp_eic_scheduler: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a scan-snapshot/argmax model.
module tb_mfp_eic_scheduler;
  localparam int CH = 8;
  localparam int PW = 3;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic [CH-1:0] pending = '0;
  logic          cfg_we = 1'b0;
  logic [5:0]    cfg_wch = '0;
  logic [PW-1:0] cfg_wp = '0;
  logic [5:0]    cfg_rch = '0;
  logic [PW-1:0] cfg_rp;
  logic [7:0]    ipl = '0;
  logic          iack = 1'b0;
  logic [7:0]    eint;
  logic [5:0]    evec;
  logic          clrv;
  logic [5:0]    clrch;
  logic          busy;

  int total = 0;
  int bad = 0;

  mfp_eic_scheduler #(.CHANNELS(CH), .PRIO_WIDTH(PW)) dut (
    .CLK(CLK), .RESETn(RESETn), .pending(pending),
    .cfg_write_enable(cfg_we), .cfg_write_channel(cfg_wch), .cfg_write_priority(cfg_wp),
    .cfg_read_channel(cfg_rch), .cfg_read_priority(cfg_rp),
    .EIC_IPL(ipl), .EIC_IAck(iack), .EIC_Interrupt(eint), .EIC_Vector(evec),
    .clear_valid(clrv), .clear_channel(clrch), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: idle / scanning (collect one masked sample per cycle, argmax at end) /
  // presenting / clearing.
  int m_phase = 0;
  int m_tab [CH];
  int m_samp [CH];
  int m_k, m_bp, m_bc;
  int e_int, e_vec, e_clr, e_clrch, e_busy;
  bit m_live = 1'b0;

  always @(posedge CLK) begin
    if (!RESETn) begin
      m_phase = 0;
      foreach (m_tab[i]) m_tab[i] = 0;
      e_int = 0; e_vec = 0; e_clr = 0; e_clrch = 0;
      m_bp = 0; m_bc = 0;
      m_live = 1'b1;
    end else begin
      e_clr = 0;
      case (m_phase)
        0: if (pending != 0) begin m_phase = 1; m_k = 0; end
        1: begin
          m_samp[m_k] = pending[m_k] ? m_tab[m_k] : 0;
          m_k++;
          if (m_k == CH) begin
            m_bp = 0; m_bc = 0;
            for (int i = 0; i < CH; i++)
              if (m_samp[i] > m_bp) begin m_bp = m_samp[i]; m_bc = i; end
            if (m_bp > int'(ipl)) begin
              m_phase = 2; e_int = m_bp; e_vec = m_bc;
            end else m_phase = 0;
          end
        end
        2: begin
          if (iack) begin
            m_phase = 3; e_int = 0; e_clr = 1; e_clrch = m_bc;
          end else if (!pending[m_bc] || m_tab[m_bc] == 0 || int'(ipl) >= m_bp) begin
            m_phase = 0; e_int = 0;
          end
        end
        default: m_phase = 0;
      endcase
      if (cfg_we && int'(cfg_wch) < CH) m_tab[int'(cfg_wch)] = int'(cfg_wp);
    end
    e_busy = (m_phase != 0) ? 1 : 0;
  end

  always @(negedge CLK) begin
    if (m_live) begin
      chk("int", int'(eint), e_int);
      chk("busy", int'(busy), e_busy);
      chk("clear_valid", int'(clrv), e_clr);
      if (e_int != 0) chk("vector", int'(evec), e_vec);
      if (e_clr != 0) chk("clear_channel", int'(clrch), e_clrch);
      chk("readback", int'(cfg_rp), (int'(cfg_rch) < CH) ? m_tab[int'(cfg_rch)] : 0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic wr(input int ch, input int p);
    cfg_we = 1'b1; cfg_wch = 6'(ch); cfg_wp = PW'(p);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_int(input int lim);
    int ok;
    ok = 0;
    for (int i = 0; i < lim && ok == 0; i++) begin
      tick();
      if (eint != 0) ok = 1;
    end
    chk("present_within_bound", ok, 1);
  endtask

  task automatic ack_drop(input int b);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    pending[b] = 1'b0;
  endtask

  initial begin
    int hi, lo, nz, b;
    // 1. reset
    tick();
    chk("rst_int", int'(eint), 0);
    chk("rst_vec", int'(evec), 0);
    chk("rst_clrv", int'(clrv), 0);
    chk("rst_clrch", int'(clrch), 0);
    chk("rst_busy", int'(busy), 0);
    for (int i = 0; i < CH; i++) begin
      cfg_rch = 6'(i); #1;
      chk("rst_table", int'(cfg_rp), 0);
    end
    RESETn = 1'b1;
    iack = 1'b1; tick(); iack = 1'b0; tick();
    iack = 1'b1; tick(); iack = 1'b0; tick();
    chk("idle_ack_int", int'(eint), 0);
    chk("idle_ack_busy", int'(busy), 0);

    // 2. single request, exact latency
    wr(3, 5);
    pending = 8'h08;
    tick(8);
    chk("single_not_yet", int'(eint), 0);
    tick();
    chk("single_int", int'(eint), 5);
    chk("single_vec", int'(evec), 3);
    iack = 1'b1; tick(); iack = 1'b0; pending = '0;
    chk("single_clrv", int'(clrv), 1);
    chk("single_clrch", int'(clrch), 3);
    chk("single_int_drop", int'(eint), 0);
    tick();
    chk("single_clrv_end", int'(clrv), 0);
    tick(2);

    // 3. arbitration
    wr(1, 4); wr(6, 4); wr(5, 6); wr(0, 0);
    pending = 8'h63;
    wait_int(20);
    chk("arb1_vec", int'(evec), 5); chk("arb1_int", int'(eint), 6);
    ack_drop(5);
    wait_int(20);
    chk("arb2_vec", int'(evec), 1); chk("arb2_int", int'(eint), 4);
    ack_drop(1);
    wait_int(20);
    chk("arb3_vec", int'(evec), 6); chk("arb3_int", int'(eint), 4);
    ack_drop(6);
    nz = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (eint != 0) nz++; end
    chk("ch0_never", nz, 0);
    pending = '0;
    tick(12);

    // 4. IPL gating
    wr(2, 3);
    ipl = 8'd3; pending = 8'h04;
    hi = 0; lo = 0; nz = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (eint != 0) nz++;
      if (busy) hi++; else lo++;
    end
    chk("ipl_blocked", nz, 0);
    chk("ipl_busy_hi_seen", int'(hi > 0), 1);
    chk("ipl_busy_lo_seen", int'(lo > 0), 1);
    ipl = 8'd2;
    wait_int(18);
    chk("ipl_int", int'(eint), 3);
    ack_drop(2);
    ipl = 8'd0;
    tick(2);

    // 5. withdraw variants on channel 3 (prio 5)
    pending = 8'h08;
    wait_int(20);
    pending = '0;
    tick();
    chk("wd_int", int'(eint), 0);
    chk("wd_clrv", int'(clrv), 0);
    tick(2);
    pending = 8'h08;
    wait_int(20);
    iack = 1'b1; pending = '0;
    tick();
    iack = 1'b0;
    chk("wd_ack_clrv", int'(clrv), 1);
    chk("wd_ack_clrch", int'(clrch), 3);
    tick(2);
    pending = 8'h08;
    wait_int(20);
    wr(3, 0);
    chk("wd_prio_hold", int'(eint), 5);
    tick();
    chk("wd_prio_int", int'(eint), 0);
    chk("wd_prio_clrv", int'(clrv), 0);
    pending = '0;
    wr(3, 5);
    tick(2);

    // 6. reset while presenting
    pending = 8'h08;
    wait_int(20);
    RESETn = 1'b0;
    tick();
    chk("mrst_int", int'(eint), 0);
    chk("mrst_clrv", int'(clrv), 0);
    chk("mrst_busy", int'(busy), 0);
    cfg_rch = 6'd3; #1;
    chk("mrst_table", int'(cfg_rp), 0);
    RESETn = 1'b1; pending = '0;
    tick();

    // randomized traffic; the bench acts as the flag logic on clear pulses
    for (int i = 0; i < 8; i++) wr(i, i);
    for (int n = 0; n < 3000; n++) begin
      if (clrv) pending[clrch[2:0]] = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        b = $urandom_range(0, CH - 1);
        pending[b] = ~pending[b];
      end
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_wch = 6'($urandom_range(0, 11));
      cfg_wp  = PW'($urandom);
      cfg_rch = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 19) == 0) ipl = 8'($urandom_range(0, 7));
      iack = (eint != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
      RESETn = ($urandom_range(0, 499) != 0);
      tick();
    end
    RESETn = 1'b1; iack = 1'b0; cfg_we = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
